// File: rtl/gnr_pkg.sv
// Shared definitions for gene-regulatory-network nodes: parameter limits and
// the truth-table index packing shared with the network generator.
package gnr_pkg;

   localparam int K_MIN     = 1;
   localparam int K_MAX     = 8;
   localparam int DIV_MIN   = 1;
   localparam int DIV_MAX   = 16;
   localparam int IDX_MAX_W = K_MAX + 1;

   // Forms {self, regs} for a k-input node; bits above k are forced to zero.
   function automatic logic [IDX_MAX_W-1:0] pack_index(input logic             self_state,
                                                       input logic [K_MAX-1:0] regs,
                                                       input int               k);
      logic [IDX_MAX_W-1:0] mask;
      mask = (IDX_MAX_W'(1) << k) - IDX_MAX_W'(1);
      return ({1'b0, regs} & mask) | (IDX_MAX_W'(self_state) << k);
   endfunction

endpackage

// File: rtl/gnr_lut_node_if.sv
// Control, regulator and status signals of one network node.
interface gnr_lut_node_if #(
   parameter int K = 6
);
   localparam int AW = K + 1;

   logic          reset_nos;
   logic          init_state;
   logic          start_s0;
   logic          start_s1;
   logic [K-1:0]  reg_s0;
   logic [K-1:0]  reg_s1;
   logic          cfg_we;
   logic [AW-1:0] cfg_addr;
   logic          cfg_data;
   logic          s0;
   logic          s1;
   logic          chg_s0;
   logic          chg_s1;
   logic          upd_s0;

   modport master (
      output reset_nos, init_state, start_s0, start_s1, reg_s0, reg_s1,
             cfg_we, cfg_addr, cfg_data,
      input  s0, s1, chg_s0, chg_s1, upd_s0
   );

   modport slave (
      input  reset_nos, init_state, start_s0, start_s1, reg_s0, reg_s1,
             cfg_we, cfg_addr, cfg_data,
      output s0, s1, chg_s0, chg_s1, upd_s0
   );

endinterface

// File: rtl/gnr_lut_ram.sv
// Truth-table storage: 1-bit entries, reset-cleared, one write port and two
// combinational read ports (slow and fast state copies).
module gnr_lut_ram #(
   parameter int AW = 7
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic          wdata,
   input  logic [AW-1:0] raddr_s0,
   input  logic [AW-1:0] raddr_s1,
   output logic          rdata_s0,
   output logic          rdata_s1
);

   localparam int DEPTH = 1 << AW;

   logic [DEPTH-1:0] lut_reg;

   // Per-entry flops so the whole table clears in the reset cycle.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
         if (rst) begin
            lut_reg[gi] <= 1'b0;
         end else if (we && (waddr == AW'(gi))) begin
            lut_reg[gi] <= wdata;
         end
      end
   end

   assign rdata_s0 = lut_reg[raddr_s0];
   assign rdata_s1 = lut_reg[raddr_s1];

endmodule

// File: rtl/gnr_lut_node.sv
// Programmable Boolean network node with slow/fast state copies for
// tortoise/hare attractor detection.
module gnr_lut_node
   import gnr_pkg::*;
#(
   parameter int K        = 6,
   parameter int SLOW_DIV = 2
) (
   input logic         clk,
   input logic         rst,
   gnr_lut_node_if.slave bus
);

   localparam int AW    = K + 1;
   localparam int DIV_W = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;

   if (K < K_MIN || K > K_MAX) begin : g_bad_k
      $error("gnr_lut_node: K out of range");
   end
   if (SLOW_DIV < DIV_MIN || SLOW_DIV > DIV_MAX) begin : g_bad_div
      $error("gnr_lut_node: SLOW_DIV out of range");
   end

   logic             s0_reg, s0_next;
   logic             s1_reg, s1_next;
   logic             chg_s0_reg, chg_s0_next;
   logic             chg_s1_reg, chg_s1_next;
   logic             upd_s0_reg, upd_s0_next;
   logic [DIV_W-1:0] div_cnt_reg, div_cnt_next;
   logic [AW-1:0]    idx_s0, idx_s1;
   logic             lut_s0, lut_s1;

   assign idx_s0 = AW'(pack_index(s0_reg, K_MAX'(bus.reg_s0), K));
   assign idx_s1 = AW'(pack_index(s1_reg, K_MAX'(bus.reg_s1), K));

   // Reads are combinational, so a same-cycle write is seen only next cycle.
   gnr_lut_ram #(.AW(AW)) u_lut (
      .clk      (clk),
      .rst      (rst),
      .we       (bus.cfg_we),
      .waddr    (bus.cfg_addr),
      .wdata    (bus.cfg_data),
      .raddr_s0 (idx_s0),
      .raddr_s1 (idx_s1),
      .rdata_s0 (lut_s0),
      .rdata_s1 (lut_s1)
   );

   always_comb begin
      s0_next      = s0_reg;
      s1_next      = s1_reg;
      chg_s0_next  = 1'b0;
      chg_s1_next  = 1'b0;
      upd_s0_next  = 1'b0;
      div_cnt_next = div_cnt_reg;
      if (bus.reset_nos) begin
         s0_next      = bus.init_state;
         s1_next      = bus.init_state;
         div_cnt_next = '0;
      end else begin
         if (bus.start_s0) begin
            if (div_cnt_reg == '0) begin
               s0_next      = lut_s0;
               chg_s0_next  = (lut_s0 != s0_reg);
               upd_s0_next  = 1'b1;
               div_cnt_next = (SLOW_DIV == 1) ? '0 : DIV_W'(1);
            end else begin
               div_cnt_next = (div_cnt_reg == DIV_W'(SLOW_DIV - 1)) ? '0
                              : div_cnt_reg + DIV_W'(1);
            end
         end
         if (bus.start_s1) begin
            s1_next     = lut_s1;
            chg_s1_next = (lut_s1 != s1_reg);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s0_reg      <= 1'b0;
         s1_reg      <= 1'b0;
         chg_s0_reg  <= 1'b0;
         chg_s1_reg  <= 1'b0;
         upd_s0_reg  <= 1'b0;
         div_cnt_reg <= '0;
      end else begin
         s0_reg      <= s0_next;
         s1_reg      <= s1_next;
         chg_s0_reg  <= chg_s0_next;
         chg_s1_reg  <= chg_s1_next;
         upd_s0_reg  <= upd_s0_next;
         div_cnt_reg <= div_cnt_next;
      end
   end

   assign bus.s0     = s0_reg;
   assign bus.s1     = s1_reg;
   assign bus.chg_s0 = chg_s0_reg;
   assign bus.chg_s1 = chg_s1_reg;
   assign bus.upd_s0 = upd_s0_reg;

endmodule

// File: tb/tb_gnr_lut_node.sv
// Bench for gnr_lut_node: three nodes (SLOW_DIV 1, 2, 3) share one stimulus
// stream and are compared against a pulse-counting reference model.
module tb_gnr_lut_node;

   localparam int K    = 2;
   localparam int NDUT = 3;
   localparam int NLUT = 1 << (K + 1);

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         reset_nos = 1'b0;
   logic         init_state = 1'b0;
   logic         start_s0 = 1'b0;
   logic         start_s1 = 1'b0;
   logic [K-1:0] reg_s0 = '0;
   logic [K-1:0] reg_s1 = '0;
   logic         cfg_we = 1'b0;
   logic [K:0]   cfg_addr = '0;
   logic         cfg_data = 1'b0;

   // {s0, s1, chg_s0, chg_s1, upd_s0} of each node
   logic [4:0]   obs [NDUT];

   int checks   = 0;
   int failures = 0;
   int txn      = 0;

   // Reference model state
   bit m_lut [NLUT];
   bit m_s0  [NDUT];
   bit m_s1  [NDUT];
   bit m_c0  [NDUT];
   bit m_c1  [NDUT];
   bit m_up  [NDUT];
   int m_n   [NDUT];

   always #5 clk = ~clk;

   for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
      gnr_lut_node_if #(.K(K)) bus ();
      assign bus.reset_nos  = reset_nos;
      assign bus.init_state = init_state;
      assign bus.start_s0   = start_s0;
      assign bus.start_s1   = start_s1;
      assign bus.reg_s0     = reg_s0;
      assign bus.reg_s1     = reg_s1;
      assign bus.cfg_we     = cfg_we;
      assign bus.cfg_addr   = cfg_addr;
      assign bus.cfg_data   = cfg_data;
      gnr_lut_node #(.K(K), .SLOW_DIV(gi + 1)) dut (
         .clk (clk),
         .rst (rst),
         .bus (bus)
      );
      assign obs[gi] = {bus.s0, bus.s1, bus.chg_s0, bus.chg_s1, bus.upd_s0};
   end

   task automatic check(input string tag, input logic got, input logic exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0b exp=%0b (txn %0d)", tag, got, exp, txn);
      end
   endtask

   // Applies one cycle of stimulus, advances the model, compares every node.
   task automatic step(input logic i_rst, input logic i_nos, input logic i_init,
                       input logic i_st0, input logic i_st1,
                       input logic [K-1:0] i_r0, input logic [K-1:0] i_r1,
                       input logic i_we, input logic [K:0] i_addr, input logic i_data);
      string names [5];
      logic [4:0] exp_v;
      bit nv;
      names = '{"upd_s0", "chg_s1", "chg_s0", "s1", "s0"};
      @(negedge clk);
      rst = i_rst; reset_nos = i_nos; init_state = i_init;
      start_s0 = i_st0; start_s1 = i_st1; reg_s0 = i_r0; reg_s1 = i_r1;
      cfg_we = i_we; cfg_addr = i_addr; cfg_data = i_data;
      for (int d = 0; d < NDUT; d++) begin
         m_c0[d] = 0; m_c1[d] = 0; m_up[d] = 0;
         if (i_rst) begin
            m_s0[d] = 0; m_s1[d] = 0; m_n[d] = 0;
         end else if (i_nos) begin
            m_s0[d] = i_init; m_s1[d] = i_init; m_n[d] = 0;
         end else begin
            if (i_st0) begin
               if (m_n[d] % (d + 1) == 0) begin
                  nv = m_lut[int'(m_s0[d]) * (1 << K) + int'(i_r0)];
                  m_c0[d] = (nv != m_s0[d]);
                  m_s0[d] = nv;
                  m_up[d] = 1;
               end
               m_n[d]++;
            end
            if (i_st1) begin
               nv = m_lut[int'(m_s1[d]) * (1 << K) + int'(i_r1)];
               m_c1[d] = (nv != m_s1[d]);
               m_s1[d] = nv;
            end
         end
      end
      if (i_rst) begin
         for (int a = 0; a < NLUT; a++) m_lut[a] = 0;
      end else if (i_we) begin
         m_lut[int'(i_addr)] = i_data;
      end
      @(posedge clk);
      #1;
      txn++;
      $display("txn %0d rst=%0b nos=%0b init=%0b st0=%0b st1=%0b r0=%0d r1=%0d we=%0b addr=%0d data=%0b",
               txn, i_rst, i_nos, i_init, i_st0, i_st1, i_r0, i_r1, i_we, i_addr, i_data);
      for (int d = 0; d < NDUT; d++) begin
         exp_v = {m_s0[d], m_s1[d], m_c0[d], m_c1[d], m_up[d]};
         for (int b = 0; b < 5; b++) begin
            check($sformatf("div%0d_%s", d + 1, names[b]), obs[d][b], exp_v[b]);
         end
      end
   endtask

   initial begin
      // Reset with a write attempt that must be ignored
      step(1, 0, 0, 0, 0, 2'b00, 2'b00, 1, 3'd7, 1);
      for (int d = 0; d < NDUT; d++) check($sformatf("rst_out_div%0d", d + 1), |obs[d], 1'b0);

      // Program lut[6] = lut[7] = 1, then self-hold / drop on the fast copy
      step(0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 3'd6, 1);
      step(0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 3'd7, 1);
      step(0, 1, 1, 0, 0, 2'b00, 2'b10, 0, 3'd0, 0);
      step(0, 0, 0, 0, 1, 2'b00, 2'b10, 0, 3'd0, 0);
      check("plan_s1_hold", obs[1][3], 1'b1);
      check("plan_chg_s1_hold", obs[1][1], 1'b0);
      step(0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 3'd0, 0);
      check("plan_s1_drop", obs[1][3], 1'b0);
      check("plan_chg_s1_drop", obs[1][1], 1'b1);

      // Divider phase: SLOW_DIV=3 updates on pulses 1 and 4
      step(0, 1, 1, 0, 0, 2'b00, 2'b00, 0, 3'd0, 0);
      for (int p = 0; p < 6; p++) begin
         step(0, 0, 0, 1, 0, K'($urandom_range(3)), 2'b00, 0, 3'd0, 0);
         check($sformatf("div3_upd_p%0d", p + 1), obs[2][0], (p % 3) == 0);
         check($sformatf("div1_upd_p%0d", p + 1), obs[0][0], 1'b1);
      end
      step(0, 1, 0, 0, 0, 2'b00, 2'b00, 0, 3'd0, 0);
      step(0, 0, 0, 1, 0, 2'b10, 2'b00, 0, 3'd0, 0);
      step(0, 0, 0, 1, 0, 2'b10, 2'b00, 0, 3'd0, 0);
      step(0, 1, 0, 0, 0, 2'b00, 2'b00, 0, 3'd0, 0);
      step(0, 0, 0, 1, 0, 2'b11, 2'b00, 0, 3'd0, 0);
      check("rearm_div3_upd", obs[2][0], 1'b1);
      check("rearm_div2_upd", obs[1][0], 1'b1);

      // Identical inputs on both copies, SLOW_DIV=1 tracks the fast copy
      for (int i = 0; i < 6; i++) begin
         logic [K-1:0] r;
         r = K'($urandom_range(3));
         step(0, 0, 0, 1, 1, r, r, 0, 3'd0, 0);
      end

      // Same-cycle write to the active index: old value first, new value next
      step(0, 1, 0, 0, 0, 2'b00, 2'b00, 1, 3'd4, 0);
      step(0, 0, 0, 0, 1, 2'b00, 2'b00, 1, 3'd0, 1);
      check("wr_same_cycle_old", obs[1][3], 1'b0);
      step(0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 3'd0, 0);
      check("wr_next_cycle_new", obs[1][3], 1'b1);

      // Mid-run rst with a write pending clears everything
      step(1, 0, 0, 1, 1, 2'b11, 2'b11, 1, 3'd5, 1);
      for (int d = 0; d < NDUT; d++) check($sformatf("midrst_out_div%0d", d + 1), |obs[d], 1'b0);
      step(0, 1, 1, 0, 0, 2'b00, 2'b00, 0, 3'd0, 0);
      step(0, 0, 0, 0, 1, 2'b00, 2'b11, 0, 3'd0, 0);
      check("lut_cleared_s1", obs[1][3], 1'b0);

      // Simultaneous strobes, each copy on its own index
      step(0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 3'd2, 1);
      step(0, 1, 0, 0, 0, 2'b00, 2'b00, 0, 3'd0, 0);
      step(0, 0, 0, 1, 1, 2'b10, 2'b01, 0, 3'd0, 0);
      check("indep_s0", obs[1][4], 1'b1);
      check("indep_s1", obs[1][3], 1'b0);

      // Randomized traffic
      for (int i = 0; i < 300; i++) begin
         step(($urandom_range(49) == 0), ($urandom_range(14) == 0), 1'($urandom),
              1'($urandom), 1'($urandom), K'($urandom), K'($urandom),
              ($urandom_range(3) == 0), 3'($urandom), 1'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
